regfile_alu_sequencer: RTL and testbench



---
 rtl/regfile_alu_pkg.sv | 31 +++
 rtl/regfile_alu_sequencer_if.sv | 42 ++++
 rtl/regfile_alu_sequencer_alu_core.sv | 66 ++++++
 rtl/regfile_alu_sequencer.sv | 172 +++++++++++++++++
 tb/tb_regfile_alu_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_alu_pkg.sv
// ----------------------------------------------------------------------------
// regfile_alu_pkg
// Shared types and constants for the register-bank execute/writeback stage.
//   alu_op_e       : 4-bit ALU opcode encoding (0..7 defined, 8..15 illegal)
//   seq_state_e    : sequencer FSM states IDLE -> READ -> EXEC -> WB
//   OP_ILLEGAL_MIN : lowest opcode value that is always illegal
// No ports; imported by the interface, alu_core and the top.
// ----------------------------------------------------------------------------
package regfile_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_SLL    = 4'd5,
        OP_SRL    = 4'd6,
        OP_PASS_A = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } seq_state_e;

    localparam logic [3:0] OP_ILLEGAL_MIN = 4'd8;

endpackage

// File: rtl/regfile_alu_sequencer_if.sv
// ----------------------------------------------------------------------------
// regfile_alu_sequencer_if
// Command channel into the execute/writeback sequencer.
//   cmd_valid : command present (master -> slave)
//   cmd_ready : sequencer can accept a command (slave -> master)
//   cmd_op    : 4-bit opcode
//   cmd_rs1   : source register A address (N bits)
//   cmd_rs2   : source register B address (N bits)
//   cmd_rd    : destination register address (N bits)
// Handshake: a command transfers on a rising clock edge where cmd_valid and
// cmd_ready are both high. The master holds the fields stable while valid is
// high and not yet accepted; the slave ignores the fields on all other edges.
// Modports: master (command source), slave (sequencer).
// ----------------------------------------------------------------------------
interface regfile_alu_sequencer_if #(
    parameter int N = 5
) ();
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [N-1:0] cmd_rs1;
    logic [N-1:0] cmd_rs2;
    logic [N-1:0] cmd_rd;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_rs1,
        output cmd_rs2,
        output cmd_rd,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_rs1,
        input  cmd_rs2,
        input  cmd_rd,
        output cmd_ready
    );
endinterface

// File: rtl/regfile_alu_sequencer_alu_core.sv
// ----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU used by the sequencer's EXEC step.
//   op      in  4  opcode (see alu_op_e)
//   a, b    in  W  operands
//   result  out W  computed value (0 when illegal)
//   carry   out 1  ADD carry-out / SUB borrow (A < B unsigned), else 0
//   illegal out 1  opcode not supported in this build
// Build option: macro ALU_SHIFT_EN enables opcodes 5 (SLL) and 6 (SRL), which
// shift A by the low $clog2(W) bits of B. Without it those opcodes are illegal.
// ----------------------------------------------------------------------------
module alu_core
    import regfile_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         illegal
);

`ifdef ALU_SHIFT_EN
    localparam int SHW = (W > 1) ? $clog2(W) : 1;
`endif

    logic [W:0] w_sum;
    logic [W:0] w_diff;

    // One extra bit on both paths: bit W is the carry for ADD and, because
    // the subtraction wraps below zero, the borrow for SUB.
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result  = '0;
        carry   = 1'b0;
        illegal = 1'b0;
        if (op >= OP_ILLEGAL_MIN) begin
            illegal = 1'b1;
        end else begin
            case (alu_op_e'(op))
                OP_ADD: begin
                    result = w_sum[W-1:0];
                    carry  = w_sum[W];
                end
                OP_SUB: begin
                    result = w_diff[W-1:0];
                    carry  = w_diff[W];
                end
                OP_AND:    result = a & b;
                OP_OR:     result = a | b;
                OP_XOR:    result = a ^ b;
                OP_PASS_A: result = a;
`ifdef ALU_SHIFT_EN
                OP_SLL:    result = a << b[SHW-1:0];
                OP_SRL:    result = a >> b[SHW-1:0];
`endif
                default:   illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/regfile_alu_sequencer.sv
// ----------------------------------------------------------------------------
// regfile_alu_sequencer
// Execute/writeback stage wrapped around an external register bank. One ALU
// command per handshake; each command walks IDLE -> READ -> EXEC -> WB.
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous active-high reset, highest priority
//   cmd        slave   command channel (regfile_alu_sequencer_if)
//   addr_rs1   out  N  bank read port 1 address (registered, held)
//   addr_rs2   out  N  bank read port 2 address (registered, held)
//   addr_rd    out  N  bank write address (registered, held)
//   data_in    out  W  bank write data (the result register)
//   we         out  1  bank write enable, WB only, legal op and rd != 0
//   rs1, rs2   in   W  operands from the bank's combinational read ports
//   done       out  1  one-cycle completion pulse (WB)
//   err        out  1  one-cycle illegal-opcode pulse, coincident with done
//   result     out  W  last computed result, held until the next EXEC
//   flag_zero  out  1  result == 0, held with result
//   flag_carry out  1  carry/borrow, held with result
//   dbg_state  out     current FSM state
// Timing: accept at edge k, operands captured at k+1, result at k+2, bank
// written at k+3 (done/we high in the cycle before it), next accept at k+4.
// Build option: ALU_SHIFT_EN (see alu_core) enables SLL/SRL.
// ----------------------------------------------------------------------------
module regfile_alu_sequencer
    import regfile_alu_pkg::*;
#(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_alu_sequencer_if.slave  cmd,
    output logic [N-1:0]            addr_rs1,
    output logic [N-1:0]            addr_rs2,
    output logic [N-1:0]            addr_rd,
    output logic [W-1:0]            data_in,
    output logic                    we,
    input  logic [W-1:0]            rs1,
    input  logic [W-1:0]            rs2,
    output logic                    done,
    output logic                    err,
    output logic [W-1:0]            result,
    output logic                    flag_zero,
    output logic                    flag_carry,
    output seq_state_e              dbg_state
);

    seq_state_e   r_state;
    seq_state_e   w_next_state;
    logic         w_accept;

    logic [3:0]   r_op;
    logic [N-1:0] r_addr_rs1;
    logic [N-1:0] r_addr_rs2;
    logic [N-1:0] r_addr_rd;
    logic [W-1:0] r_opa;
    logic [W-1:0] r_opb;
    logic [W-1:0] r_result;
    logic         r_zero;
    logic         r_carry;
    logic         r_illegal;

    logic [W-1:0] w_alu_result;
    logic         w_alu_carry;
    logic         w_alu_illegal;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobes. WB strobes are gated by rst so an aborting
    // reset never lets a write reach the bank on that edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        cmd.cmd_ready = 1'b0;
        we            = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd.cmd_ready = 1'b1;
                if (cmd.cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_READ;
                end
            end
            ST_READ: w_next_state = ST_EXEC;
            ST_EXEC: w_next_state = ST_WB;
            ST_WB: begin
                w_next_state = ST_IDLE;
                if (!rst) begin
                    done = 1'b1;
                    err  = r_illegal;
                    // Register 0 is never written; illegal ops never write.
                    we   = !r_illegal && (r_addr_rd != '0);
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= '0;
            r_addr_rs1 <= '0;
            r_addr_rs2 <= '0;
            r_addr_rd  <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op       <= cmd.cmd_op;
                r_addr_rs1 <= cmd.cmd_rs1;
                r_addr_rs2 <= cmd.cmd_rs2;
                r_addr_rd  <= cmd.cmd_rd;
            end
            // The bank read is combinational on the held addresses, so the
            // operands are valid by the end of READ.
            if (r_state == ST_READ) begin
                r_opa <= rs1;
                r_opb <= rs2;
            end
            if (r_state == ST_EXEC) begin
                r_illegal <= w_alu_illegal;
                // An illegal op leaves result and flags as they were.
                if (!w_alu_illegal) begin
                    r_result <= w_alu_result;
                    r_zero   <= (w_alu_result == '0);
                    r_carry  <= w_alu_carry;
                end
            end
        end
    end

    alu_core #(
        .W (W)
    ) u_alu (
        .op      (r_op),
        .a       (r_opa),
        .b       (r_opb),
        .result  (w_alu_result),
        .carry   (w_alu_carry),
        .illegal (w_alu_illegal)
    );

    assign addr_rs1   = r_addr_rs1;
    assign addr_rs2   = r_addr_rs2;
    assign addr_rd    = r_addr_rd;
    assign data_in    = r_result;
    assign result     = r_result;
    assign flag_zero  = r_zero;
    assign flag_carry = r_carry;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_regfile_alu_sequencer
// Bench for regfile_alu_sequencer with a behavioural 2^N x W register bank
// (register 0 reads as zero). Commands push expected completions into a
// scoreboard; a negedge monitor pops them when done pulses.
// ----------------------------------------------------------------------------
module tb_regfile_alu_sequencer;
    import regfile_alu_pkg::*;

    localparam int N = 5;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_alu_sequencer_if #(.N(N)) tb_if ();

    logic [N-1:0] addr_rs1, addr_rs2, addr_rd;
    logic [W-1:0] data_in, rs1, rs2, result;
    logic         we, done, err, flag_zero, flag_carry;
    seq_state_e   dbg_state;

    regfile_alu_sequencer #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (tb_if),
        .addr_rs1   (addr_rs1),
        .addr_rs2   (addr_rs2),
        .addr_rd    (addr_rd),
        .data_in    (data_in),
        .we         (we),
        .rs1        (rs1),
        .rs2        (rs2),
        .done       (done),
        .err        (err),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .dbg_state  (dbg_state)
    );

    // ---------------- register bank model ----------------
    logic [W-1:0] bank [2**N];
    logic         bank_clr, bank_load;
    logic [N-1:0] load_addr;
    logic [W-1:0] load_data;

    always @(posedge clk) begin
        if (bank_clr) begin
            for (int i = 0; i < 2**N; i++) bank[i] <= '0;
        end else if (bank_load) begin
            bank[load_addr] <= load_data;
        end else if (we && addr_rd != '0) begin
            bank[addr_rd] <= data_in;
        end
    end

    assign rs1 = (addr_rs1 == '0) ? '0 : bank[addr_rs1];
    assign rs2 = (addr_rs2 == '0) ? '0 : bank[addr_rs2];

    // ---------------- scoreboard state ----------------
    logic [11:0]  exp_q[$];      // {err, we, carry, zero, result}
    logic [12:0]  exp_wr_q[$];   // {rd, data}
    int           acc_q[$];
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] exp_regs [2**N];
    logic [W-1:0] cur_res;
    logic         cur_z, cur_c;
    logic [11:0]  mon_e;
    logic [12:0]  mon_w;
    int           wt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU: returns {illegal, carry, result}.
    function automatic logic [9:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
        logic [W-1:0] r;
        logic c, ill;
        r = '0; c = 1'b0; ill = 1'b0; s = 0;
        case (op)
            4'd0: begin s = int'(a) + int'(b); r = s[7:0]; c = (s > 255); end
            4'd1: begin s = int'(a) - int'(b); r = s[7:0]; c = (a < b); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd7: r = a;
`ifdef ALU_SHIFT_EN
            4'd5: r = a << b[2:0];
            4'd6: r = a >> b[2:0];
`endif
            default: ill = 1'b1;
        endcase
        return {ill, c, r};
    endfunction

    // ---------------- completion monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (tb_if.cmd_valid && tb_if.cmd_ready) acc_q.push_back(cyc);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", {31'b0, done}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_bundle", {20'b0, err, we, flag_carry, flag_zero, result}, {20'b0, mon_e});
                    if (mon_e[10] && exp_wr_q.size() > 0) begin
                        mon_w = exp_wr_q.pop_front();
                        check("wb_target", {19'b0, addr_rd, data_in}, {19'b0, mon_w});
                    end
                    if (acc_q.size() > 0) check("latency", cyc - acc_q.pop_front(), 32'd3);
                    else check("latency_no_accept", acc_q.size(), 32'd1);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load(input logic [N-1:0] a, input logic [W-1:0] v);
        bank_load = 1'b1; load_addr = a; load_data = v;
        @(posedge clk); #1;
        bank_load = 1'b0;
        exp_regs[a] = v;
    endtask

    task automatic send(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] d, input bit expect_done, output int waited);
        logic [9:0]   m;
        logic [W-1:0] va, vb;
        bit           wr;
        va = (a == '0) ? '0 : exp_regs[a];
        vb = (b == '0) ? '0 : exp_regs[b];
        if (expect_done) begin
            m = model(op, va, vb);
            if (m[9]) begin
                exp_q.push_back({1'b1, 1'b0, cur_c, cur_z, cur_res});
            end else begin
                cur_res = m[7:0]; cur_c = m[8]; cur_z = (m[7:0] == '0);
                wr = (d != '0);
                exp_q.push_back({1'b0, wr, cur_c, cur_z, cur_res});
                if (wr) begin
                    exp_wr_q.push_back({d, cur_res});
                    exp_regs[d] = cur_res;
                end
            end
        end
        tb_if.cmd_valid = 1'b1;
        tb_if.cmd_op = op; tb_if.cmd_rs1 = a; tb_if.cmd_rs2 = b; tb_if.cmd_rd = d;
        waited = 0;
        while (!tb_if.cmd_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 20) check("accept_timeout", {31'b0, tb_if.cmd_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        tb_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !tb_if.cmd_ready) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, exp_q.size(), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tb_if.cmd_valid = 1'b0;
        tb_if.cmd_op = '0; tb_if.cmd_rs1 = '0; tb_if.cmd_rs2 = '0; tb_if.cmd_rd = '0;
        bank_clr = 1'b1; bank_load = 1'b0; load_addr = '0; load_data = '0;
        for (int i = 0; i < 2**N; i++) exp_regs[i] = '0;
        cur_res = '0; cur_z = 1'b0; cur_c = 1'b0;

        // Reset held for two edges.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",   {31'b0, tb_if.cmd_ready}, 32'd1);
        check("rst_we",      {31'b0, we}, 32'd0);
        check("rst_done",    {31'b0, done}, 32'd0);
        check("rst_err",     {31'b0, err}, 32'd0);
        check("rst_result",  {24'b0, result}, 32'd0);
        check("rst_flags",   {30'b0, flag_carry, flag_zero}, 32'd0);
        check("rst_addr",    {17'b0, addr_rs1, addr_rs2, addr_rd}, 32'd0);
        check("rst_data_in", {24'b0, data_in}, 32'd0);
        check("rst_state",   {30'b0, dbg_state}, {30'b0, ST_IDLE});
        rst = 1'b0;
        bank_clr = 1'b0;
        @(posedge clk); #1;

        load(5'd1, 8'hF0);
        load(5'd2, 8'h20);
        load(5'd8, 8'h01);
        load(5'd9, 8'h03);

        // ADD with carry into r3.
        send(OP_ADD, 5'd1, 5'd2, 5'd3, 1'b1, wt);
        idle();
        check("read_addr_held", {22'b0, addr_rs1, addr_rs2}, {22'b0, 5'd1, 5'd2});
        wait_quiet("q_add");
        check("add_result", {24'b0, result}, 32'h10);
        check("add_carry",  {31'b0, flag_carry}, 32'd1);

        // Read back r3 without writing.
        send(OP_PASS_A, 5'd3, 5'd0, 5'd0, 1'b1, wt);
        idle();
        wait_quiet("q_readback");
        check("readback_r3", {24'b0, result}, 32'h10);

        // SUB into r0: borrow set, write suppressed.
        send(OP_SUB, 5'd2, 5'd1, 5'd0, 1'b1, wt);
        idle();
        wait_quiet("q_sub_r0");
        check("sub_result", {24'b0, result}, 32'h30);
        check("sub_borrow", {31'b0, flag_carry}, 32'd1);

        // Illegal opcode: err with done, result held.
        send(4'hC, 5'd1, 5'd2, 5'd5, 1'b1, wt);
        idle();
        wait_quiet("q_illegal");
        check("illegal_result_held", {24'b0, result}, 32'h30);

        // r0 reads zero; written into r7.
        send(OP_PASS_A, 5'd0, 5'd0, 5'd7, 1'b1, wt);
        idle();
        wait_quiet("q_r0");
        check("r0_reads_zero", {24'b0, result}, 32'd0);
        check("r0_zero_flag",  {31'b0, flag_zero}, 32'd1);

        // r5 untouched by the illegal command.
        send(OP_PASS_A, 5'd5, 5'd0, 5'd0, 1'b1, wt);
        idle();
        wait_quiet("q_r5");

        // Random operands across the legal non-shift ops.
        load(5'd10, 8'($urandom_range(0, 255)));
        load(5'd11, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 6; i++) begin
            logic [3:0] op_tab [6];
            op_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7};
            send(op_tab[i], 5'd10, 5'd11, 5'(16 + i), 1'b1, wt);
            idle();
            wait_quiet("q_random");
        end

        // Back-to-back dependency with valid held high.
        send(OP_ADD, 5'd1, 5'd2, 5'd4, 1'b1, wt);
        send(OP_XOR, 5'd4, 5'd1, 5'd6, 1'b1, wt);
        check("b2b_ready_low_cycles", wt, 32'd3);
        idle();
        wait_quiet("q_b2b");
        check("b2b_xor_result", {24'b0, result}, 32'hE0);

        // Shift opcodes (legal or illegal depending on build).
        send(4'd5, 5'd8, 5'd9, 5'd13, 1'b1, wt);
        idle();
        wait_quiet("q_sll");
`ifdef ALU_SHIFT_EN
        check("sll_result", {24'b0, result}, 32'h08);
`endif
        send(4'd6, 5'd1, 5'd9, 5'd14, 1'b1, wt);
        idle();
        wait_quiet("q_srl");

        // Reset during EXEC aborts the command.
        send(OP_ADD, 5'd1, 5'd1, 5'd15, 1'b0, wt);
        idle();
        check("abort_in_read", {30'b0, dbg_state}, {30'b0, ST_READ});
        @(posedge clk); #1;
        check("abort_in_exec", {30'b0, dbg_state}, {30'b0, ST_EXEC});
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_done",   {31'b0, done}, 32'd0);
        check("abort_we",     {31'b0, we}, 32'd0);
        check("abort_ready",  {31'b0, tb_if.cmd_ready}, 32'd1);
        check("abort_result", {24'b0, result}, 32'd0);
        rst = 1'b0;
        acc_q.delete();
        cur_res = '0; cur_z = 1'b0; cur_c = 1'b0;
        @(posedge clk); #1;
        check("abort_no_late_done", {30'b0, done, we}, 32'd0);

        // r15 must not have been written.
        send(OP_PASS_A, 5'd15, 5'd0, 5'd0, 1'b1, wt);
        idle();
        wait_quiet("q_r15");
        check("abort_no_write", {24'b0, result}, 32'd0);

        check("queue_drained", exp_q.size() + exp_wr_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
